div_unit: RTL and testbench

Multicycle 32-bit signed divider serving the DIV instruction of the multicycle datapath. The control FSM pulses `start` while A/B hold rs/rt, then waits for `done` before loading HI/LO. Division by zero raises `div0` toward the control FSM's ZeroDiv exception path. It uses one restoring-division iteration per cycle.

---
 rtl/div_unit.sv | 121 ++++++++++++
 tb/tb_div_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// 32-bit restoring divider (MIPS DIV semantics, DIVU via DIV_DIVU_EN); 33 cycles accept-to-done.
// start is taken only in IDLE and ignored while busy; b==0 pulses div0 instead of starting.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef DIV_DIVU_EN
  input  logic             unsigned_op,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] rem, rem_nx, quo, quo_nx, dvsr, dvsr_nx, hi_nx, lo_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             qsign, qsign_nx, rsign, rsign_nx;
  logic             busy_nx, done_nx, div0_nx;
  logic             uop;
  logic [WIDTH:0]   sh_rem, diff;

`ifdef DIV_DIVU_EN
  assign uop = unsigned_op;
`else
  assign uop = 1'b0;
`endif

  // The dividend is shifted out of quo into rem one bit per iteration.
  assign sh_rem = {rem, quo[WIDTH-1]};
  assign diff   = sh_rem - {1'b0, dvsr};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      cnt   <= '0;
      qsign <= 1'b0;
      rsign <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      div0  <= 1'b0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
      quo   <= quo_nx;
      dvsr  <= dvsr_nx;
      cnt   <= cnt_nx;
      qsign <= qsign_nx;
      rsign <= rsign_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      div0  <= div0_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    quo_nx   = quo;
    dvsr_nx  = dvsr;
    cnt_nx   = cnt;
    qsign_nx = qsign;
    rsign_nx = rsign;
    hi_nx    = hi;
    lo_nx    = lo;
    busy_nx  = busy;
    done_nx  = 1'b0;
    div0_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (b == '0) begin
            div0_nx = 1'b1;
          end else begin
            dvsr_nx  = (!uop && b[WIDTH-1]) ? (~b + 1'b1) : b;
            quo_nx   = (!uop && a[WIDTH-1]) ? (~a + 1'b1) : a;
            rem_nx   = '0;
            qsign_nx = !uop && (a[WIDTH-1] ^ b[WIDTH-1]);
            rsign_nx = !uop && a[WIDTH-1];
            cnt_nx   = '0;
            busy_nx  = 1'b1;
            state_nx = CALC;
          end
        end
      end
      CALC: begin
        // diff MSB set means the trial subtraction went negative: restore.
        rem_nx = diff[WIDTH] ? sh_rem[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_nx = {quo[WIDTH-2:0], ~diff[WIDTH]};
        cnt_nx = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
      end
      FIX: begin
        lo_nx    = qsign ? (~quo + 1'b1) : quo;
        hi_nx    = rsign ? (~rem + 1'b1) : rem;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: scoreboard of expected {lo,hi} checked on every done pulse.
module tb_div_unit;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        uop;
  logic [31:0] hi, lo;
  logic        busy, done, div0;

  int   passed = 0;
  int   total  = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
`ifdef DIV_DIVU_EN
    .unsigned_op(uop),
`endif
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div0       (div0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Independent reference using 64-bit signed arithmetic (no overflow at -2^31 / -1).
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    res_t   r;
    r.lo = 32'(sx / sy);
    r.hi = 32'(sx % sy);
    return r;
  endfunction

  always @(negedge clk) begin
    res_t r;
    if (done || div0) chk("done_div0_exclusive", 32'(done & div0), 32'd0);
    if (reset && done) begin
      chk("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        r = sb.pop_front();
        chk("lo", lo, r.lo);
        chk("hi", hi, r.hi);
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is visible.
  task automatic run_div(input logic [31:0] ta, input logic [31:0] tb_, input res_t e,
                         input logic tu, input logic poke);
    int   lat = 0;
    logic got = 1'b0;
    logic saw_div0 = 1'b0;
    a = ta; b = tb_; uop = tu; start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0; a = ~ta; b = 32'h0; uop = ~tu;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (div0) saw_div0 = 1'b1;
      if (done) got = 1'b1;
      else if (busy) lat++;
      if (poke && i == 5) begin
        start = 1'b1; a = 32'd1234; b = 32'd0;
      end
      if (poke && i == 6) start = 1'b0;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'd33);
    chk("no_div0", 32'(saw_div0), 32'd0);
    chk("busy_low_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; a = '0; b = '0; uop = 1'b0;
    #3;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_div0", 32'(div0), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_div(32'd100, 32'd7, res_t'({32'd14, 32'd2}), 1'b0, 1'b0);
    run_div(32'hFFFFFFF9, 32'd2, res_t'({32'hFFFFFFFD, 32'hFFFFFFFF}), 1'b0, 1'b1);
    // Back-to-back: start driven in the done cycle of the previous operation.
    run_div(32'd7, 32'hFFFFFFFE, res_t'({32'hFFFFFFFD, 32'd1}), 1'b0, 1'b0);

    a = 32'd5; b = 32'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("div0_pulse", 32'(div0), 32'd1);
    chk("div0_busy", 32'(busy), 32'd0);
    chk("div0_done", 32'(done), 32'd0);
    chk("div0_lo_hold", lo, 32'hFFFFFFFD);
    chk("div0_hi_hold", hi, 32'd1);
    @(negedge clk);
    chk("div0_fall", 32'(div0), 32'd0);
    chk("div0_busy2", 32'(busy), 32'd0);

    run_div(32'h80000000, 32'hFFFFFFFF, res_t'({32'h80000000, 32'd0}), 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == 0) rb = 32'd3;
      if ($urandom_range(0, 1) == 1) rb = ~rb + 1'b1;
      run_div(ra, rb, model(ra, rb), 1'b0, 1'b0);
    end

    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_div0", 32'(div0), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_abort_busy", 32'(busy), 32'd0);
    run_div(32'd9, 32'd3, res_t'({32'd3, 32'd0}), 1'b0, 1'b0);

`ifdef DIV_DIVU_EN
    run_div(32'hFFFFFFFF, 32'd2, res_t'({32'h7FFFFFFF, 32'd1}), 1'b1, 1'b0);
`endif
    run_div(32'hFFFFFFFF, 32'd2, res_t'({32'd0, 32'hFFFFFFFF}), 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
